// File: rtl/sisc_ifetch_if.sv
// Instruction-fetch unit bundle: loader writes, core branch redirect, fetch outputs.
// No backpressure: every signal is sampled or updated on each rising clock edge.
interface sisc_ifetch_if #(
    parameter int AW = 8
);
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          br_taken;
    logic [AW-1:0] br_addr;
    logic [31:0]   IR;
    logic [AW-1:0] PC;
    logic [2:0]    phase;
    logic          instr_done;
    logic          halted;

    modport master (
        input  ld_en, ld_addr, ld_data, br_taken, br_addr,
        output IR, PC, phase, instr_done, halted
    );

    modport slave (
        output ld_en, ld_addr, ld_data, br_taken, br_addr,
        input  IR, PC, phase, instr_done, halted
    );
endinterface

// File: rtl/sisc_ifetch.sv
// Instruction fetch for sisc: 5-cycle instruction period, IR valid one edge after FETCH.
// No backpressure; branch taken only in EXECUTE, HALT opcode parks the unit until reset.
module sisc_ifetch #(
    parameter int         AW      = 8,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic          CLK,
    input  logic          RST_F,
    sisc_ifetch_if.master bus
);

    typedef enum logic [2:0] {
        PH_FETCH   = 3'd0,
        PH_DECODE  = 3'd1,
        PH_EXECUTE = 3'd2,
        PH_MEM     = 3'd3,
        PH_WB      = 3'd4,
        PH_HALTED  = 3'd5
    } phase_e;

    logic [31:0]   mem_q [2**AW];
    phase_e        phase_q, phase_d;
    logic [31:0]   ir_q, ir_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          halted_q, halted_d;
    logic          done_q, done_d;

    // Program storage is not reset so a reloaded program survives a core reset.
    always_ff @(posedge CLK) begin
        if (bus.ld_en) begin
            mem_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        done_d   = 1'b0;
        case (phase_q)
            PH_FETCH: begin
                ir_d    = mem_q[pc_q];
                pc_d    = pc_q + AW'(1);
                phase_d = PH_DECODE;
            end
            PH_DECODE: begin
                if (ir_q[31:28] == HALT_OP) begin
                    phase_d  = PH_HALTED;
                    halted_d = 1'b1;
                end else begin
                    phase_d  = PH_EXECUTE;
                end
            end
            PH_EXECUTE: begin
                if (bus.br_taken) begin
                    pc_d = bus.br_addr;
                end
                phase_d = PH_MEM;
            end
            PH_MEM: begin
                phase_d = PH_WB;
                // Registered so the pulse lines up exactly with the WB cycle.
                done_d  = 1'b1;
            end
            PH_WB:     phase_d = PH_FETCH;
            PH_HALTED: phase_d = PH_HALTED;
            default:   phase_d = PH_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            phase_q  <= PH_FETCH;
            ir_q     <= 32'h0;
            pc_q     <= '0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            done_q   <= done_d;
        end
    end

    assign bus.IR         = ir_q;
    assign bus.PC         = pc_q;
    assign bus.phase      = phase_q;
    assign bus.instr_done = done_q;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_sisc_ifetch.sv
// Bench for sisc_ifetch: expected fetches are queued at stimulus time and popped on each DECODE.
module tb_sisc_ifetch;

    logic CLK = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 CLK = ~CLK;

    sisc_ifetch_if #(.AW(8)) bi ();
    sisc_ifetch_if #(.AW(2)) bi2 ();

    sisc_ifetch #(.AW(8), .HALT_OP(4'hF)) dut (.CLK(CLK), .RST_F(rst_n), .bus(bi.master));
    sisc_ifetch #(.AW(2), .HALT_OP(4'hF)) dut2 (.CLK(CLK), .RST_F(rst2_n), .bus(bi2.master));

    typedef struct {
        logic [31:0] ir;
        logic [7:0]  pc;
        int          edge_n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [31:0] prog [5] = '{32'h00000000, 32'h8801000A, 32'h88020007, 32'h80213002, 32'hF0000000};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        bi.ld_en   = 1'b1;
        bi.ld_addr = a;
        bi.ld_data = d;
        step();
        bi.ld_en   = 1'b0;
    endtask

    // Pops one expected fetch and compares it against the AW=8 unit.
    task automatic pop_fetch(input string tag, input int e);
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected fetch at edge %0d IR=%h", tag, e, bi.IR);
        end else begin
            x = sb.pop_front();
            if (bi.IR !== x.ir || bi.PC !== x.pc || e != x.edge_n) begin
                bad++;
                $display("FAIL %s fetch: IR=%h PC=%0d edge=%0d, want IR=%h PC=%0d edge=%0d",
                         tag, bi.IR, bi.PC, e, x.ir, x.pc, x.edge_n);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        bi.ld_en = 1'b0; bi.ld_addr = '0; bi.ld_data = '0; bi.br_taken = 1'b0; bi.br_addr = '0;
        bi2.ld_en = 1'b0; bi2.ld_addr = '0; bi2.ld_data = '0; bi2.br_taken = 1'b0; bi2.br_addr = '0;
        #2;
        total++;
        if (bi.IR !== 32'h0 || bi.PC !== 8'h0 || bi.phase !== 3'd0 || bi.halted !== 1'b0 || bi.instr_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state IR=%h PC=%0d phase=%0d halted=%b done=%b, want all zero",
                     bi.IR, bi.PC, bi.phase, bi.halted, bi.instr_done);
        end
    endtask

    task automatic test_program();
        int  done_cnt = 0;
        int  done_long = 0;
        int  halt_edge = 0;
        logic prev_done = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load(8'(i), prog[i]);
            sb.push_back('{ir: prog[i], pc: 8'(i + 1), edge_n: 1 + 5 * i});
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            step();
            if (bi.phase === 3'd1) pop_fetch("program", e);
            if (bi.instr_done === 1'b1) begin
                done_cnt++;
                if (prev_done) done_long++;
            end
            prev_done = bi.instr_done;
            if (bi.halted === 1'b1 && halt_edge == 0) halt_edge = e;
            if (e == 24) begin
                bi.br_taken = 1'b1;
                bi.br_addr  = 8'h33;
            end
        end
        bi.br_taken = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL program_pending %0d fetches missing, want 0", sb.size());
        end
        total++;
        if (done_cnt != 4 || done_long != 0) begin
            bad++; $display("FAIL instr_done_pulses count=%0d multi=%0d, want 4 and 0", done_cnt, done_long);
        end
        total++;
        if (halt_edge != 22) begin
            bad++; $display("FAIL halt_edge got %0d, want 22", halt_edge);
        end
        total++;
        if (bi.phase !== 3'd5 || bi.PC !== 8'd5 || bi.IR !== 32'hF0000000 || bi.halted !== 1'b1 || bi.instr_done !== 1'b0) begin
            bad++;
            $display("FAIL halted_state phase=%0d PC=%0d IR=%h halted=%b done=%b, want 5 5 F0000000 1 0",
                     bi.phase, bi.PC, bi.IR, bi.halted, bi.instr_done);
        end
    endtask

    task automatic test_branch();
        rst_n = 1'b0;
        load(8'd0, 32'h00000000);
        load(8'd1, 32'hF0000000);
        load(8'd9, 32'h8801000A);
        load(8'd10, 32'hF0000000);
        sb.push_back('{ir: 32'h00000000, pc: 8'd1, edge_n: 1});
        sb.push_back('{ir: 32'h8801000A, pc: 8'd10, edge_n: 6});
        rst_n = 1'b1;
        bi.br_taken = 1'b1;
        bi.br_addr  = 8'd3;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (bi.phase === 3'd1) pop_fetch("branch", e);
            if (e == 2) bi.br_addr = 8'd9;
            if (e == 3) begin
                bi.br_addr = 8'd3;
                total++;
                if (bi.PC !== 8'd9) begin
                    bad++; $display("FAIL branch_pc after EXECUTE PC=%0d, want 9", bi.PC);
                end
            end
            if (e == 5) begin
                total++;
                if (bi.PC !== 8'd9) begin
                    bad++; $display("FAIL branch_ignored_mem_wb PC=%0d, want 9", bi.PC);
                end
            end
        end
        bi.br_taken = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL branch_pending %0d fetches missing, want 0", sb.size());
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        rst2_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bi2.ld_en   = 1'b1;
            bi2.ld_addr = 2'(i);
            bi2.ld_data = 32'h0;
            step();
        end
        bi2.ld_en = 1'b0;
        for (int i = 0; i < 5; i++) sb.push_back('{ir: 32'h0, pc: 8'((i + 1) % 4), edge_n: 1 + 5 * i});
        rst2_n = 1'b1;
        for (int e = 1; e <= 21; e++) begin
            step();
            if (bi2.phase === 3'd1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL wrap unexpected fetch at edge %0d", e);
                end else begin
                    x = sb.pop_front();
                    if (bi2.IR !== x.ir || {6'b0, bi2.PC} !== x.pc || e != x.edge_n) begin
                        bad++;
                        $display("FAIL wrap fetch: IR=%h PC=%0d edge=%0d, want IR=%h PC=%0d edge=%0d",
                                 bi2.IR, bi2.PC, e, x.ir, x.pc, x.edge_n);
                    end
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL wrap_pending %0d fetches missing, want 0", sb.size());
        end
        rst2_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) load(8'(i), prog[i]);
        rst_n = 1'b1;
        for (int e = 1; e <= 13; e++) step();
        total++;
        if (bi.phase !== 3'd3 || bi.IR !== 32'h88020007) begin
            bad++; $display("FAIL midreset_setup phase=%0d IR=%h, want 3 88020007", bi.phase, bi.IR);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bi.IR !== 32'h0 || bi.PC !== 8'h0 || bi.phase !== 3'd0 || bi.halted !== 1'b0 || bi.instr_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async IR=%h PC=%0d phase=%0d halted=%b done=%b, want all zero",
                     bi.IR, bi.PC, bi.phase, bi.halted, bi.instr_done);
        end
        step();
        step();
        sb.push_back('{ir: 32'h00000000, pc: 8'd1, edge_n: 1});
        sb.push_back('{ir: 32'h8801000A, pc: 8'd2, edge_n: 6});
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (bi.phase === 3'd1) pop_fetch("midreset", e);
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL midreset_pending %0d fetches missing, want 0", sb.size());
        end
    endtask

    task automatic test_read_before_write();
        rst_n = 1'b0;
        load(8'd0, 32'h00001111);
        load(8'd1, 32'hF0000000);
        sb.push_back('{ir: 32'h00001111, pc: 8'd1, edge_n: 1});
        sb.push_back('{ir: 32'h12345678, pc: 8'd1, edge_n: 6});
        rst_n      = 1'b1;
        bi.ld_en   = 1'b1;
        bi.ld_addr = 8'd0;
        bi.ld_data = 32'h12345678;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (bi.phase === 3'd1) pop_fetch("rbw", e);
            if (e == 1) bi.ld_en = 1'b0;
            if (e == 2) begin
                bi.br_taken = 1'b1;
                bi.br_addr  = 8'd0;
            end
            if (e == 3) bi.br_taken = 1'b0;
        end
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL rbw_pending %0d fetches missing, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_read_before_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sisc_ifetch.md
Name: sisc_ifetch

Overview:
- Instruction-fetch unit: the supplying end of the sisc core's IR interface.
- Holds a loadable instruction memory and the program counter, and presents one 32-bit instruction on IR per 5-cycle instruction period (FETCH, DECODE, EXECUTE, MEM, WB).
- Accepts branch redirects from the core and stops on HALT.
- Replaces bench-driven IR sequencing; sits between the program loader and sisc.

Parameters:
- AW, 8, instruction memory address width (depth 2^AW words).
- HALT_OP, 4'hF, opcode in IR[31:28] that halts fetch.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_F  input  1  asynchronous active-low reset.
- ld_en  input  1  memory write enable from the program loader.
- ld_addr  input  AW  memory write address.
- ld_data  input  32  memory write data.
- br_taken  input  1  branch-taken from the core; sampled only in EXECUTE.
- br_addr  input  AW  branch target; sampled with br_taken.
- IR  output  32  current instruction to the core.
- PC  output  AW  program counter (address of the next fetch).
- phase  output  3  0=FETCH, 1=DECODE, 2=EXECUTE, 3=MEM, 4=WB, 5=HALTED.
- instr_done  output  1  one-cycle pulse while phase==WB.
- halted  output  1  high while in HALTED.

Behaviour:
- Reset (RST_F low, asynchronous): IR=0, PC=0, phase=FETCH, halted=0. instr_done follows phase and is 0.
- Reset does not clear memory contents.
- Reset mid-instruction abandons it; the first edge after release executes FETCH at address 0.
- Phase sequence: FETCH, DECODE, EXECUTE, MEM, WB, then back to FETCH. Each phase lasts exactly 1 cycle, so one instruction takes 5 cycles.
- FETCH edge: IR <= mem[PC]; PC <= PC+1 modulo 2^AW (2^AW-1 wraps to 0). IR is stable for the remaining 4 cycles.
- DECODE edge, IR[31:28]==HALT_OP: phase <= HALTED, halted <= 1. IR and PC are unchanged.
- DECODE edge, any other opcode: phase <= EXECUTE.
- EXECUTE edge: if br_taken==1 then PC <= br_addr, otherwise PC is unchanged. br_taken is ignored in all other phases.
- MEM, WB: no state change besides phase. instr_done=1 during WB only.
- HALTED: terminal until reset. IR holds the HALT word; br_taken is ignored; instr_done=0.
- Memory write: on the edge with ld_en=1, mem[ld_addr] <= ld_data. Writes are legal in any phase, including HALTED.
- Same-edge FETCH read and write to the same address: the read returns the old word (read-before-write). The new word is seen on the next fetch of that address.
- Memory reads are combinational from PC into the IR register; IR has no extra latency beyond the FETCH edge.
- Unwritten memory is undefined. The bench must load every address it fetches.

Test Plan:
- Preload mem[0..4]=00000000, 8801000A, 88020007, 80213002, F0000000; release reset -> IR=00000000 after the 1st edge, then 8801000A at edge 6, 88020007 at edge 11, 80213002 at edge 16, F0000000 at edge 21. halted=1 and phase=5 after edge 22; PC=5 thereafter.
- Count instr_done pulses over the same program -> exactly 4 single-cycle pulses (the NOP and three ALU instructions), none after HALT.
- mem[0]=NOP, mem[1]=HALT, mem[9]=8801000A; assert br_taken=1, br_addr=9 during EXECUTE of instruction 0 -> next FETCH reads address 9 (IR=8801000A), PC=10. br_taken=1 held during other phases -> no effect.
- AW=2, mem[0..3] all NOP, br_taken=0 -> PC sequence 1,2,3,0,1 across five fetches (wrap-around).
- Drop RST_F during MEM of the 3rd instruction -> IR=0, PC=0, phase=0 immediately, without waiting for a clock edge; after release, refetch from address 0 with memory intact.
- ld_en=1 to address PC on a FETCH edge with ld_data=12345678 -> IR gets the old word; after branching back to that address, IR=12345678.
